// File: rtl/action_round_sequencer.sv
// action_round_sequencer: steps one learning round through NUM_STAGES chained
// en/start/done submodules and grants the shared memory write port to the active stage.
module action_round_sequencer #(
   parameter int NUM_STAGES = 4,
   parameter int WORD_WIDTH = 16,
   parameter int TIMEOUT    = 64,
   parameter int CNT_WIDTH  = 16,
   localparam int KW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
   input  logic                             i_clock,
   input  logic                             i_rst,
   input  logic                             i_go,
   input  logic                             i_halt,
   output logic [NUM_STAGES-1:0]            o_stage_en,
   output logic [NUM_STAGES-1:0]            o_stage_start,
   input  logic [NUM_STAGES-1:0]            i_stage_done,
   input  logic [NUM_STAGES*WORD_WIDTH-1:0] i_stage_addr,
   input  logic [NUM_STAGES-1:0]            i_stage_wr_en,
   input  logic [NUM_STAGES*WORD_WIDTH-1:0] i_stage_data,
   output logic [WORD_WIDTH-1:0]            o_mem_addr,
   output logic                             o_mem_wr_en,
   output logic [WORD_WIDTH-1:0]            o_mem_data,
   output logic                             o_busy,
   output logic                             o_round_done,
   output logic                             o_timeout_err,
   output logic [KW-1:0]                    o_err_stage,
   output logic [CNT_WIDTH-1:0]             o_round_count
);
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [2:0] {S_IDLE, S_EN, S_START, S_WAIT, S_NEXT, S_FINISH} state_t;

   state_t                r_state, w_state_nx;
   logic [KW-1:0]         r_k, w_k_nx, r_err_stage, w_err_stage_nx;
   logic [TW-1:0]         r_timer, w_timer_nx;
   logic                  r_timeout_err, w_timeout_err_nx;
   logic [CNT_WIDTH-1:0]  r_round_count, w_round_count_nx;
   logic [NUM_STAGES-1:0] r_stage_en, r_stage_start, w_onehot;
   logic                  r_busy, r_round_done, w_sel;

   // Pulse outputs are registered from the next state so they line up with it.
   assign w_onehot = NUM_STAGES'(1) << w_k_nx;

   always_ff @(posedge i_clock or posedge i_rst) begin
      if (i_rst) begin
         r_state       <= S_IDLE;
         r_k           <= '0;
         r_timer       <= '0;
         r_timeout_err <= 1'b0;
         r_err_stage   <= '0;
         r_round_count <= '0;
         r_stage_en    <= '0;
         r_stage_start <= '0;
         r_busy        <= 1'b0;
         r_round_done  <= 1'b0;
      end else begin
         r_state       <= w_state_nx;
         r_k           <= w_k_nx;
         r_timer       <= w_timer_nx;
         r_timeout_err <= w_timeout_err_nx;
         r_err_stage   <= w_err_stage_nx;
         r_round_count <= w_round_count_nx;
         r_stage_en    <= (w_state_nx == S_EN) ? w_onehot : '0;
         r_stage_start <= (w_state_nx == S_START) ? w_onehot : '0;
         r_busy        <= w_state_nx != S_IDLE;
         r_round_done  <= w_state_nx == S_FINISH;
      end
   end

   always_comb begin
      w_state_nx       = r_state;
      w_k_nx           = r_k;
      w_timer_nx       = r_timer;
      w_timeout_err_nx = r_timeout_err;
      w_err_stage_nx   = r_err_stage;
      w_round_count_nx = r_round_count;
      if (r_state != S_IDLE && i_halt)
         w_state_nx = S_IDLE;
      else
         case (r_state)
            S_IDLE:
               if (i_go && !i_halt) begin
                  w_state_nx       = S_EN;
                  w_k_nx           = '0;
                  w_timeout_err_nx = 1'b0;
                  w_err_stage_nx   = '0;
               end
            S_EN:    w_state_nx = S_START;
            S_START: begin
               w_timer_nx = '0;
               w_state_nx = S_WAIT;
            end
            S_WAIT:
               if (i_stage_done[r_k])
                  w_state_nx = S_NEXT;
               else if (r_timer == TW'(TIMEOUT - 1)) begin
                  w_state_nx       = S_IDLE;
                  w_timeout_err_nx = 1'b1;
                  w_err_stage_nx   = r_k;
               end else
                  w_timer_nx = r_timer + 1'b1;
            S_NEXT:
               if (r_k == KW'(NUM_STAGES - 1)) begin
                  w_state_nx       = S_FINISH;
                  w_round_count_nx = r_round_count + 1'b1;
               end else begin
                  w_k_nx     = r_k + 1'b1;
                  w_state_nx = S_EN;
               end
            default: w_state_nx = S_IDLE;
         endcase
   end

   assign w_sel         = (r_state == S_START) || (r_state == S_WAIT);
   assign o_mem_addr    = w_sel ? i_stage_addr[r_k*WORD_WIDTH +: WORD_WIDTH] : '0;
   assign o_mem_data    = w_sel ? i_stage_data[r_k*WORD_WIDTH +: WORD_WIDTH] : '0;
   assign o_mem_wr_en   = w_sel & i_stage_wr_en[r_k];
   assign o_stage_en    = r_stage_en;
   assign o_stage_start = r_stage_start;
   assign o_busy        = r_busy;
   assign o_round_done  = r_round_done;
   assign o_timeout_err = r_timeout_err;
   assign o_err_stage   = r_err_stage;
   assign o_round_count = r_round_count;
endmodule

// File: tb/tb_action_round_sequencer.sv
// tb_action_round_sequencer: directed rounds against stub stages; a negedge monitor
// pops expected en/start/write/round_done events from scoreboard queues.
module tb_action_round_sequencer;
   localparam int N = 4, W = 16, KW = 2, CW = 16;

   logic clk = 1'b0, rst, go, halt;
   logic [N-1:0] en, start, done, wr;
   logic [N*W-1:0] addr, data;
   logic [W-1:0] m_addr, m_data;
   logic m_wr, busy, rdone, terr;
   logic [KW-1:0] estg;
   logic [CW-1:0] rcnt;

   int checks = 0, errors = 0, cyc = 0, go_cyc = 0, exp_count = 0;
   int dly[N], wr_src[N], s_cnt[N];
   bit never[N], wr_on[N], wr_always[N];
   logic [N-1:0] s_done, s_act;
   int en_q[$], st_q[$], lat_q[$];
   logic [2*W-1:0] wr_q[$];

   action_round_sequencer dut (
      .i_clock(clk), .i_rst(rst), .i_go(go), .i_halt(halt),
      .o_stage_en(en), .o_stage_start(start), .i_stage_done(done),
      .i_stage_addr(addr), .i_stage_wr_en(wr), .i_stage_data(data),
      .o_mem_addr(m_addr), .o_mem_wr_en(m_wr), .o_mem_data(m_data),
      .o_busy(busy), .o_round_done(rdone), .o_timeout_err(terr),
      .o_err_stage(estg), .o_round_count(rcnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Stub stage k raises done on WAIT cycle dly[k] and holds it until its next en.
   always @(posedge clk)
      if (rst) begin
         s_done <= '0;
         s_act  <= '0;
      end else
         for (int k = 0; k < N; k++)
            if (en[k]) begin
               s_done[k] <= 1'b0;
               s_act[k]  <= 1'b0;
            end else if (start[k]) begin
               if (!never[k] && dly[k] == 1) s_done[k] <= 1'b1;
               else begin
                  s_act[k] <= 1'b1;
                  s_cnt[k] <= 2;
               end
            end else if (s_act[k]) begin
               if (!never[k] && s_cnt[k] == dly[k]) begin
                  s_done[k] <= 1'b1;
                  s_act[k]  <= 1'b0;
               end else s_cnt[k] <= s_cnt[k] + 1;
            end
   assign done = s_done;

   always_comb begin
      wr = '0;
      for (int k = 0; k < N; k++) wr[k] = wr_on[k] & (wr_always[k] | s_act[wr_src[k]]);
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk)
      if (!rst) begin
         if (en != 0) begin
            check("en_expected", 64'(en_q.size() > 0), 1);
            if (en_q.size() > 0) check("en_onehot", en, N'(1) << en_q.pop_front());
         end
         if (start != 0) begin
            check("start_expected", 64'(st_q.size() > 0), 1);
            if (st_q.size() > 0) check("start_onehot", start, N'(1) << st_q.pop_front());
         end
         if (m_wr) begin
            check("write_expected", 64'(wr_q.size() > 0), 1);
            if (wr_q.size() > 0) check("mem_write", {m_addr, m_data}, wr_q.pop_front());
         end
         if (rdone) begin
            check("round_done_expected", 64'(lat_q.size() > 0), 1);
            if (lat_q.size() > 0) check("round_latency", cyc - go_cyc, lat_q.pop_front());
         end
      end

   task automatic check_zero(input string tag);
      check({tag, "_en"}, en, 0);
      check({tag, "_start"}, start, 0);
      check({tag, "_mem_addr"}, m_addr, 0);
      check({tag, "_mem_wr"}, m_wr, 0);
      check({tag, "_mem_data"}, m_data, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_round_done"}, rdone, 0);
      check({tag, "_timeout_err"}, terr, 0);
      check({tag, "_err_stage"}, estg, 0);
      check({tag, "_round_count"}, rcnt, 0);
   endtask

   task automatic push_stages(input int n);
      for (int k = 0; k < n; k++) begin
         en_q.push_back(k);
         st_q.push_back(k);
      end
   endtask

   task automatic set_dly(input int d);
      for (int k = 0; k < N; k++) dly[k] = d;
   endtask

   task automatic do_go();
      @(negedge clk);
      go = 1'b1;
      go_cyc = cyc;
      @(negedge clk);
      go = 1'b0;
   endtask

   task automatic step_to(input int i);
      while (cyc - go_cyc < i) @(negedge clk);
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (busy && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("idle_within_budget", busy, 0);
   endtask

   task automatic run_round(input int lat);
      push_stages(N);
      lat_q.push_back(lat);
      exp_count++;
      do_go();
      check("busy_after_go", busy, 1);
      wait_idle(300);
      check("round_count", rcnt, exp_count);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; go = 1'b0; halt = 1'b0; addr = '0; data = '0;
      for (int k = 0; k < N; k++) begin
         dly[k] = 1; never[k] = 0; wr_on[k] = 0; wr_always[k] = 0; wr_src[k] = k;
      end
      repeat (3) @(negedge clk);
      check_zero("reset");
      rst = 1'b0;

      set_dly(3);
      run_round(25);

      set_dly(1);
      dly[1] = 3;
      addr[1*W +: W] = 16'h0002; data[1*W +: W] = 16'h0001;
      addr[3*W +: W] = 16'h07FE; data[3*W +: W] = 16'hBEEF;
      wr_on[1] = 1; wr_on[3] = 1; wr_src[3] = 1;
      repeat (2) wr_q.push_back({16'h0002, 16'h0001});
      run_round(19);
      wr_on[1] = 0; wr_on[3] = 0; wr_src[3] = 3; dly[1] = 1;

      addr[0 +: W] = 16'h0010; data[0 +: W] = 16'h00AA;
      wr_on[0] = 1; wr_always[0] = 1;
      repeat (2) wr_q.push_back({16'h0010, 16'h00AA});
      run_round(17);
      wr_on[0] = 0; wr_always[0] = 0;

      never[2] = 1;
      push_stages(3);
      do_go();
      wait_idle(300);
      check("timeout_length", cyc - go_cyc, 75);
      check("timeout_err", terr, 1);
      check("err_stage", estg, 2);
      check("timeout_round_count", rcnt, exp_count);
      never[2] = 0;
      push_stages(N);
      lat_q.push_back(17);
      exp_count++;
      do_go();
      check("go_clears_timeout_err", terr, 0);
      check("go_clears_err_stage", estg, 0);
      wait_idle(300);
      check("after_timeout_round_count", rcnt, exp_count);

      set_dly(2);
      run_round(21);
      run_round(21);

      set_dly(3);
      push_stages(2);
      do_go();
      step_to(4);
      go = 1'b1;
      step_to(5);
      go = 1'b0;
      step_to(10);
      halt = 1'b1;
      step_to(11);
      halt = 1'b0;
      check("halt_busy", busy, 0);
      step_to(40);
      check("halt_no_more_en", en_q.size(), 0);
      check("halt_round_count", rcnt, exp_count);
      check("halt_timeout_err", terr, 0);
      @(negedge clk);
      go = 1'b1; halt = 1'b1;
      @(negedge clk);
      go = 1'b0; halt = 1'b0;
      check("halt_beats_go", busy, 0);

      set_dly(2);
      push_stages(N);
      do_go();
      step_to(18);
      rst = 1'b1;
      #1;
      check_zero("mid_reset");
      exp_count = 0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      set_dly(1);
      run_round(17);

      check("en_q_drained", en_q.size(), 0);
      check("st_q_drained", st_q.size(), 0);
      check("wr_q_drained", wr_q.size(), 0);
      check("lat_q_drained", lat_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
